// File: rtl/xor_bind_pkg.sv
// Shared types and helpers for the XOR bind monitor: FSM state encoding and a
// saturating counter increment.
package xor_bind_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StErr  = 2'd2
  } state_e;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/xor_bind_chan.sv
// One monitor channel: XOR reference, compare against the observed value and a
// saturating mismatch counter.
module xor_bind_chan
  import xor_bind_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8,
  parameter bit          DOIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] gold,
  output logic             mismatch,
  output logic             mismatch_now,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] ref_val;
  logic [WIDTH-1:0] gold_q, gold_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Disabled channels still compare, against an all-zero reference.
  assign ref_val      = DOIT ? (a ^ b) : '0;
  assign mismatch_now = (ref_val != c);

  always_comb begin
    gold_d     = gold_q;
    mismatch_d = 1'b0;
    cnt_d      = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (valid) begin
      gold_d     = ref_val;
      mismatch_d = mismatch_now;
      if (mismatch_now) begin
        cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gold_q     <= '0;
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      gold_q     <= gold_d;
      mismatch_q <= mismatch_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gold     = gold_q;
  assign mismatch = mismatch_q;
  assign cnt      = cnt_q;

endmodule

// File: rtl/xor_bind_monitor.sv
// Bindable XOR checker: per-channel reference/compare/count plus a shared
// IDLE/RUN/ERR tracker that latches the first failing channel.
module xor_bind_monitor
  import xor_bind_pkg::*;
#(
  parameter int unsigned         WIDTH     = 1,
  parameter int unsigned         CHANNELS  = 2,
  parameter logic [CHANNELS-1:0] DOIT_MASK = '1,
  parameter int unsigned         CNT_W     = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           valid_i,
  input  logic                                           clr_i,
  input  logic [CHANNELS*WIDTH-1:0]                      a_i,
  input  logic [CHANNELS*WIDTH-1:0]                      b_i,
  input  logic [CHANNELS*WIDTH-1:0]                      c_i,
  output logic [CHANNELS*WIDTH-1:0]                      gold_o,
  output logic                                           gold_valid_o,
  output logic [CHANNELS-1:0]                            mismatch_o,
  output logic                                           err_o,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] first_ch_o,
  output logic [CHANNELS*CNT_W-1:0]                      err_cnt_o,
  output logic [1:0]                                     state_o
);

  localparam int unsigned ChIdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] mm_now;
  logic                any_mm;
  state_e              state_q, state_d;
  logic                err_q, err_d;
  logic                gold_valid_q, gold_valid_d;
  logic [ChIdxW-1:0]   first_ch_q, first_ch_d;
  logic [ChIdxW-1:0]   lowest_mm;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    xor_bind_chan #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .DOIT  (DOIT_MASK[n])
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .valid        (valid_i),
      .clr          (clr_i),
      .a            (a_i[n*WIDTH +: WIDTH]),
      .b            (b_i[n*WIDTH +: WIDTH]),
      .c            (c_i[n*WIDTH +: WIDTH]),
      .gold         (gold_o[n*WIDTH +: WIDTH]),
      .mismatch     (mismatch_o[n]),
      .mismatch_now (mm_now[n]),
      .cnt          (err_cnt_o[n*CNT_W +: CNT_W])
    );
  end

  assign any_mm = |mm_now;

  // Scan high-to-low so the lowest failing index wins.
  always_comb begin
    lowest_mm = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mm_now[i]) begin
        lowest_mm = ChIdxW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_i) begin
            state_d = any_mm ? StErr : StRun;
          end
        end
        StRun: begin
          if (valid_i && any_mm) begin
            state_d = StErr;
          end
        end
        StErr:   state_d = StErr;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    first_ch_d   = first_ch_q;
    err_d        = (state_d == StErr);
    gold_valid_d = valid_i && !clr_i;
    if (clr_i) begin
      first_ch_d = '0;
    end else if (state_d == StErr && state_q != StErr) begin
      first_ch_d = lowest_mm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      err_q        <= 1'b0;
      gold_valid_q <= 1'b0;
      first_ch_q   <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      gold_valid_q <= gold_valid_d;
      first_ch_q   <= first_ch_d;
    end
  end

  assign state_o      = state_q;
  assign err_o        = err_q;
  assign gold_valid_o = gold_valid_q;
  assign first_ch_o   = first_ch_q;

endmodule

// File: tb/tb_xor_bind_monitor.sv
// Directed self-checking bench: a 2-channel 1-bit monitor with mask 2'b10 and
// a 3-channel 8-bit monitor with mask 3'b101.
module tb_xor_bind_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, clr;
  logic [1:0]  a, b, c;
  logic [1:0]  gold, mismatch;
  logic        gold_valid, err;
  logic [0:0]  first_ch;
  logic [3:0]  err_cnt;
  logic [1:0]  state;

  logic        valid2, clr2;
  logic [23:0] a2, b2, c2, gold2;
  logic        gold_valid2, err2;
  logic [2:0]  mismatch2;
  logic [1:0]  first_ch2;
  logic [23:0] err_cnt2;
  logic [1:0]  state2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  xor_bind_monitor #(
    .WIDTH     (1),
    .CHANNELS  (2),
    .DOIT_MASK (2'b10),
    .CNT_W     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid),
    .clr_i        (clr),
    .a_i          (a),
    .b_i          (b),
    .c_i          (c),
    .gold_o       (gold),
    .gold_valid_o (gold_valid),
    .mismatch_o   (mismatch),
    .err_o        (err),
    .first_ch_o   (first_ch),
    .err_cnt_o    (err_cnt),
    .state_o      (state)
  );

  xor_bind_monitor #(
    .WIDTH     (8),
    .CHANNELS  (3),
    .DOIT_MASK (3'b101),
    .CNT_W     (8)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid2),
    .clr_i        (clr2),
    .a_i          (a2),
    .b_i          (b2),
    .c_i          (c2),
    .gold_o       (gold2),
    .gold_valid_o (gold_valid2),
    .mismatch_o   (mismatch2),
    .err_o        (err2),
    .first_ch_o   (first_ch2),
    .err_cnt_o    (err_cnt2),
    .state_o      (state2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; clr = 1'b0; a = '0; b = '0; c = '0;
    valid2 = 1'b0; clr2 = 1'b0; a2 = '0; b2 = '0; c2 = '0;
    tick();
    tick();
    chk("rst_gold", 32'(gold), 32'h0);
    chk("rst_gvalid", 32'(gold_valid), 32'h0);
    chk("rst_mm", 32'(mismatch), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_first", 32'(first_ch), 32'h0);
    chk("rst_cnt", 32'(err_cnt), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    rst = 1'b0;

    // Masked channel 0 forced to 0; channel 1 is 1^0.
    a = 2'b11; b = 2'b01; c = 2'b10; valid = 1'b1;
    a2 = {3{8'hF0}}; b2 = {3{8'h0F}}; c2 = {8'hFF, 8'h00, 8'hFF}; valid2 = 1'b1;
    tick();
    valid = 1'b0; valid2 = 1'b0;
    chk("ok_gold", 32'(gold), 32'h2);
    chk("ok_gvalid", 32'(gold_valid), 32'h1);
    chk("ok_mm", 32'(mismatch), 32'h0);
    chk("ok_state", 32'(state), 32'h1);
    chk("ok_err", 32'(err), 32'h0);
    chk("w8_gold", 32'(gold2), 32'hFF00FF);
    chk("w8_mm", 32'(mismatch2), 32'h0);
    chk("w8_state", 32'(state2), 32'h1);

    tick();
    chk("idle_gvalid", 32'(gold_valid), 32'h0);
    chk("idle_gold_hold", 32'(gold), 32'h2);
    chk("idle_mm", 32'(mismatch), 32'h0);
    chk("w8_cnt", 32'(err_cnt2), 32'h0);

    // Masked channel 0 sees c=1 against reference 0.
    a = 2'b01; b = 2'b00; c = 2'b01; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("e0_mm", 32'(mismatch), 32'h1);
    chk("e0_err", 32'(err), 32'h1);
    chk("e0_first", 32'(first_ch), 32'h0);
    chk("e0_cnt", 32'(err_cnt), 32'h1);
    chk("e0_state", 32'(state), 32'h2);

    // Clear beats a simultaneous mismatching sample.
    clr = 1'b1; valid = 1'b1;
    tick();
    clr = 1'b0; valid = 1'b0;
    chk("clr_state", 32'(state), 32'h0);
    chk("clr_cnt", 32'(err_cnt), 32'h0);
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_gvalid", 32'(gold_valid), 32'h0);
    chk("clr_mm", 32'(mismatch), 32'h0);

    // Five channel-1 mismatches: counter saturates at 3.
    a = 2'b10; b = 2'b00; c = 2'b00; valid = 1'b1;
    tick();
    chk("sat1_cnt", 32'(err_cnt), 32'h4);
    chk("sat1_first", 32'(first_ch), 32'h1);
    chk("sat1_mm", 32'(mismatch), 32'h2);
    tick();
    chk("sat2_cnt", 32'(err_cnt), 32'h8);
    tick();
    chk("sat3_cnt", 32'(err_cnt), 32'hC);
    tick();
    chk("sat4_cnt", 32'(err_cnt), 32'hC);
    // Channel 0 also fails now; first_ch must stay 1.
    c = 2'b01;
    tick();
    chk("sat5_cnt", 32'(err_cnt), 32'hD);
    chk("sat5_first", 32'(first_ch), 32'h1);
    chk("sat5_state", 32'(state), 32'h2);

    // Reset during ERR with a mismatching sample pending.
    rst = 1'b1;
    tick();
    rst = 1'b0; valid = 1'b0;
    chk("rst2_gold", 32'(gold), 32'h0);
    chk("rst2_gvalid", 32'(gold_valid), 32'h0);
    chk("rst2_mm", 32'(mismatch), 32'h0);
    chk("rst2_err", 32'(err), 32'h0);
    chk("rst2_first", 32'(first_ch), 32'h0);
    chk("rst2_cnt", 32'(err_cnt), 32'h0);
    chk("rst2_state", 32'(state), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/xor_bind_monitor.md
XOR_BIND_MONITOR -- requirements
Module: xor_bind_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 1, bit width of each channel's operands.
REQ-002 SHALL have parameter CHANNELS, default 2, number of independent channels (>=1).
REQ-003 SHALL have parameter DOIT_MASK, default all-ones [CHANNELS-1:0]: bit n=1 enables XOR on channel n; bit n=0 forces the channel's reference result to 0.
REQ-004 SHALL have parameter CNT_W, default 8, width of each per-channel mismatch counter.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port valid_i  input  1  sample strobe for a_i/b_i/c_i.
REQ-008 SHALL have port clr_i  input  1  clears counters, error state and capture registers.
REQ-009 SHALL have ports a_i, b_i, c_i  input  CHANNELS*WIDTH  operands and observed DUT output, channel n at bits [n*WIDTH +: WIDTH].
REQ-010 SHALL have port gold_o  output  CHANNELS*WIDTH  registered reference result.
REQ-011 SHALL have port gold_valid_o  output  1  gold_o/mismatch_o valid.
REQ-012 SHALL have port mismatch_o  output  CHANNELS  per-channel compare failure for the current result.
REQ-013 SHALL have port err_o  output  1  sticky error flag.
REQ-014 SHALL have port first_ch_o  output  max(1,$clog2(CHANNELS))  lowest channel index of the first failing sample.
REQ-015 SHALL have port err_cnt_o  output  CHANNELS*CNT_W  per-channel saturating mismatch counts.
REQ-016 SHALL have port state_o  output  2  FSM state encoding.

Function
REQ-017 Reference per channel n SHALL be DOIT_MASK[n] ? a^b : {WIDTH{1'b0}}.
REQ-018 When valid_i=1, gold_o and mismatch_o[n]=(reference != c_i channel n) SHALL be registered with exactly 1-cycle latency; gold_valid_o=1 in that following cycle only.
REQ-019 When valid_i=0, gold_valid_o SHALL be 0 next cycle, mismatch_o SHALL be 0, gold_o SHALL hold.
REQ-020 FSM states SHALL be IDLE=0 (no sample since reset/clear), RUN=1, ERR=2; encoding 3 unused and SHALL recover to IDLE.
REQ-021 IDLE->RUN on valid_i with no mismatch; IDLE or RUN->ERR on valid_i with any mismatch; ERR SHALL persist until clr_i or rst.
REQ-022 On entry to ERR, first_ch_o SHALL capture the lowest mismatching channel index; later mismatches SHALL NOT change it.
REQ-023 err_o SHALL equal (state==ERR), registered.
REQ-024 Each err_cnt channel SHALL increment by 1 per sampled mismatch on that channel, in every state, saturating at 2^CNT_W-1 (no wrap).
REQ-025 clr_i SHALL, next cycle, set state IDLE, counters 0, first_ch_o 0, err_o 0, gold_valid_o 0, mismatch_o 0; clr_i SHALL take priority over a simultaneous valid_i (sample discarded).
REQ-026 Channels with DOIT_MASK[n]=0 SHALL still be compared (c_i nonzero is a mismatch).

Reset
REQ-027 rst SHALL act on the rising clk edge only and take priority over clr_i and valid_i.
REQ-028 After reset: gold_o 0, gold_valid_o 0, mismatch_o 0, err_o 0, first_ch_o 0, err_cnt_o 0, state_o IDLE.
REQ-029 rst asserted mid-sample SHALL discard that sample; no partial counter update.

Structure
REQ-030 A shared package xor_bind_pkg SHALL hold the FSM state enum (IDLE/RUN/ERR) and a saturating-increment function.
REQ-031 A single sub-module xor_bind_chan SHALL implement one channel (reference, compare, saturating counter), instantiated CHANNELS times via generate; top holds FSM and capture.
REQ-032 Module SHALL be attachable with bind using .* connections and parameter pass-through of DOIT_MASK.

Verification (CHANNELS=2, WIDTH=1, DOIT_MASK=2'b10, CNT_W=2 unless stated)
REQ-033 a=2'b11,b=2'b01,c=2'b10,valid -> next cycle gold_o=2'b10, mismatch_o=0, state RUN, err_o 0.
REQ-034 a=2'b01,b=0,c=2'b01,valid -> mismatch_o=2'b01, err_o=1, first_ch_o=0, err_cnt ch0=1, state ERR.
REQ-035 Five consecutive ch1 mismatches -> err_cnt ch1 reads 1,2,3,3,3 (saturates), first_ch_o=1.
REQ-036 clr_i and mismatching valid_i same cycle -> next cycle state IDLE, counts 0, err_o 0, gold_valid_o 0.
REQ-037 rst asserted during ERR with valid_i mismatch -> all outputs at reset values next cycle.
REQ-038 WIDTH=8, CHANNELS=3, DOIT_MASK=3'b101: a=8'hF0,b=8'h0F per channel, c=8'hFF,8'h00,8'hFF -> gold_o={FF,00,FF}, no mismatch.
